regfile_flags_wb: RTL
=====================

Name: regfile_flags_wb

Overview:
- Writeback/operand stage wrapped around the 8-bit ALU.
- Holds the CPU's 8 x 8-bit general registers and drives the ALU A/B operands through two combinational read ports.
- Captures the ALU result into the destination register and latches the ALU status into a flags register (Z, C, V, N).
- Evaluates a 3-bit branch condition against the registered flags for the PC-select logic.

Parameters:
- NREGS, 8, number of general registers; address width is fixed at 3 bits.
- R0_ZERO, 1, when 1, register 0 is hardwired to 8'h00 and writes to it are discarded.
- BYPASS, 1, when 1, read ports forward a same-cycle write (write-through); when 0, reads return the pre-edge contents.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr_a  input  3  read port A address; data feeds ALU A.
- rd_data_a  output  8  register[rd_addr_a], combinational.
- rd_addr_b  input  3  read port B address; data feeds ALU B.
- rd_data_b  output  8  register[rd_addr_b], combinational.
- wr_en  input  1  write the ALU result this cycle.
- wr_addr  input  3  destination register.
- wr_data  input  8  ALU result (out_put).
- flag_we  input  1  update the flags register this cycle.
- zero_in  input  1  ALU zero.
- carry_in  input  1  ALU carry.
- overflow_in  input  1  ALU overflow.
- cond  input  3  branch condition select.
- flag_z, flag_c, flag_v, flag_n  output  1 each  registered flags.
- cond_true  output  1  combinational condition result from the registered flags.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registers and all four flags clear to 0 immediately, independent of clk.
  - rd_data_a and rd_data_b read 8'h00. cond_true follows the cleared flags: 1 for cond 000, 010, 100; 0 otherwise.
- Reset release:
  - The first rising edge with rst_n high is the first edge that may write.
  - A wr_en or flag_we asserted while rst_n is low has no effect.
- Write:
  - On a rising edge with wr_en=1, reg[wr_addr] <= wr_data. Latency is 1 edge.
  - With R0_ZERO=1 and wr_addr=0, the write is dropped and reg0 always reads 8'h00.
- Reads:
  - Purely combinational; both ports may address the same register.
  - With BYPASS=1, when wr_en=1 and rd_addr matches wr_addr, rd_data returns wr_data in the same cycle. The R0_ZERO rule takes precedence: a read of addr 0 returns 8'h00 even during a write to 0.
  - With BYPASS=0, reads return the stored value until after the edge.
- Flags:
  - On a rising edge with flag_we=1: Z<=zero_in, C<=carry_in, V<=overflow_in, N<=wr_data[7].
  - N is taken from wr_data regardless of wr_en.
  - With flag_we=0, all flags hold.
  - Flags and register write are independent; a compare-style op uses flag_we=1 with wr_en=0.
- Condition evaluation, from the registered flags (never from the *_in inputs):
  - 000 always (1)
  - 001 EQ (Z)
  - 010 NE (!Z)
  - 011 CS (C)
  - 100 CC (!C)
  - 101 VS (V)
  - 110 MI (N)
  - 111 LT (N^V)
- Simultaneous events:
  - A write and two reads to the same address in one cycle are legal and follow the BYPASS rule.
  - A reset asserting mid-cycle aborts the pending write; nothing is committed at the next edge.
- No X propagation: all outputs are defined for every input combination after reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing reg3=8'h5A -> rd_data_a(addr 3)=8'h00 immediately, all flags 0, cond=010 gives cond_true=1, cond=001 gives cond_true=0.
- Write/read: wr_en=1, wr_addr=5, wr_data=8'hC3 at edge -> next cycle rd_addr_a=5 and rd_addr_b=5 both read 8'hC3; other registers remain 8'h00.
- R0: write 8'hFF to addr 0 -> reads of addr 0 return 8'h00, both in the same cycle (BYPASS=1) and after the edge.
- Bypass: BYPASS=1, wr addr 2 = 8'h11 with rd_addr_a=2 in the same cycle -> rd_data_a=8'h11 before the edge; with BYPASS=0 -> old value 8'h00 until after the edge.
- Flags/cond: flag_we=1, wr_data=8'h80, carry_in=0, overflow_in=1, zero_in=0 (result of 8'h7F+8'h01) -> after the edge N=1, V=1, C=0, Z=0; cond=111 gives cond_true=0, cond=101 gives 1, cond=110 gives 1.
- Flag hold/compare: flag_we=1, wr_en=0, zero_in=1 -> Z=1 and cond=001 gives 1, register contents unchanged; next cycle flag_we=0 with zero_in=0 -> Z stays 1.

Source files
------------

// File: rtl/regfile_flags_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_flags_wb                                                         |
// | Register file for ALU operands and results, with a Z/C/V/N flags         |
// | register and branch-condition evaluation.                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_flags_wb #(
    parameter int NREGS   = 8,
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [2:0] rd_addr_b,
    output logic [7:0] rd_data_b,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       flag_we,
    input  logic       zero_in,
    input  logic       carry_in,
    input  logic       overflow_in,
    input  logic [2:0] cond,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_n,
    output logic       cond_true
);

    logic [7:0] regs_q [NREGS];
    logic [7:0] regs_d [NREGS];
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       wr_ok;
    logic [2:0] rd_addr [2];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        wr_ok  = wr_en && (int'(wr_addr) < NREGS) && !(R0_ZERO && (wr_addr == 3'd0));
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Flags packed as {Z, C, V, N}; N comes from the result bus even when the register write is off.
    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d = {zero_in, carry_in, overflow_in, wr_data[7]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
            flags_q <= 4'h0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // The hardwired-zero register wins over write-through forwarding.
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [7:0] port_data;
        always_comb begin
            port_data = 8'h00;
            if (R0_ZERO && (rd_addr[p] == 3'd0)) begin
                port_data = 8'h00;
            end else if (int'(rd_addr[p]) < NREGS) begin
                if (BYPASS && wr_en && (rd_addr[p] == wr_addr)) begin
                    port_data = wr_data;
                end else begin
                    port_data = regs_q[rd_addr[p]];
                end
            end
        end
    end

    assign rd_data_a = g_rd_port[0].port_data;
    assign rd_data_b = g_rd_port[1].port_data;

    assign flag_z = flags_q[3];
    assign flag_c = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[3];
            3'b010:  cond_true = !flags_q[3];
            3'b011:  cond_true = flags_q[2];
            3'b100:  cond_true = !flags_q[2];
            3'b101:  cond_true = flags_q[1];
            3'b110:  cond_true = flags_q[0];
            default: cond_true = flags_q[0] ^ flags_q[1];
        endcase
    end

endmodule
`default_nettype wire
